if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the width of the pc and instruction fields.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port flush  input  1  SHALL be the branch-taken discard request from the execute path.
REQ-006 Port inValid  input  1  SHALL indicate that the fetch stage presents a valid entry.
REQ-007 Port pcIn  input  WIDTH  SHALL be the fetch-stage pc, the address of the next sequential instruction.
REQ-008 Port instructionIn  input  WIDTH  SHALL be the fetched instruction word.
REQ-009 Port outReady  input  1  SHALL indicate that the decode stage consumes the head entry this cycle.
REQ-010 Port outValid  output  1  SHALL indicate that the head entry is valid.
REQ-011 Port pcOut  output  WIDTH  SHALL be the pc field of the head entry.
REQ-012 Port instructionOut  output  WIDTH  SHALL be the instruction field of the head entry.
REQ-013 Port full  output  1  SHALL be high when the queue holds DEPTH entries; the fetch stage uses it as its freeze.
REQ-014 Port count  output  $clog2(DEPTH)+1  SHALL be the number of occupied entries.

Function
REQ-015 The queue SHALL be a circular FIFO with a read pointer and a write pointer, each $clog2(DEPTH) bits wide, plus an occupancy counter.
REQ-016 A push SHALL occur when inValid=1, full=0 and flush=0; it writes {pcIn, instructionIn} at the write pointer and advances the write pointer by one modulo DEPTH.
REQ-017 A pop SHALL occur when outValid=1, outReady=1 and flush=0; it advances the read pointer by one modulo DEPTH.
REQ-018 When a push and a pop occur in the same cycle, count SHALL remain unchanged and both pointers SHALL advance.
REQ-019 When only a push occurs, count SHALL increment by 1; when only a pop occurs, count SHALL decrement by 1.
REQ-020 When full=1, inValid SHALL be ignored, the entry SHALL NOT be written, and no state SHALL change because of it, even if a pop occurs in the same cycle.
REQ-021 When empty (count=0), outReady SHALL be ignored and no pop SHALL occur.
REQ-022 The outputs SHALL be show-ahead: pcOut and instructionOut SHALL combinationally reflect the entry at the read pointer while count>0.
REQ-023 While count=0, outValid, pcOut and instructionOut SHALL all be 0.
REQ-024 outValid SHALL equal (count!=0), and full SHALL equal (count==DEPTH); both SHALL depend only on registered state.
REQ-025 Latency: an entry pushed in cycle N SHALL appear on the outputs in cycle N+1 at the earliest; there is no bypass from input to output.
REQ-026 flush=1 SHALL, at the next rising edge, set both pointers to 0 and count to 0.
REQ-027 flush SHALL have priority over any push or pop in the same cycle; the entry presented that cycle is discarded.
REQ-028 The pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication of entries.
REQ-029 Storage contents SHALL NOT be required to be cleared by flush or reset; only the pointers and count are cleared.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for a clock edge, force both pointers to 0, count to 0, outValid to 0, full to 0, pcOut to 0 and instructionOut to 0.
REQ-031 An assertion of rst while entries are queued or a push or pop is in progress SHALL discard all entries; no push or pop SHALL take effect on the edge where rst is high.
REQ-032 After rst deasserts, the first push SHALL be accepted on the first rising edge with inValid=1.

Verification
REQ-033 Fill: reset, push pc 4, 8, 12, 16 with outReady=0 -> count=4, full=1; a fifth push with pc 20 is ignored; head pc is 4.
REQ-034 Drain: after the fill, hold outReady=1 for 4 cycles -> outputs show pc 4, 8, 12, 16 in order, then outValid=0 and pcOut=0.
REQ-035 Steady stream: inValid=1 and outReady=1 continuously for 10 cycles starting from count=1 -> count stays 1, the pointers wrap, and no pc is skipped or repeated.
REQ-036 Flush: with count=3, assert flush together with inValid=1 (pc 0x40) and outReady=1 -> next cycle count=0, outValid=0; the following push of pc 0x80 appears at the head.
REQ-037 Full with pop: with count=4, assert inValid=1 and outReady=1 -> count=3 and the input entry is not stored.
REQ-038 Asynchronous reset: with count=2, pulse rst between clock edges -> outValid drops immediately and count=0 before the next edge.

Source files
------------

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Show-ahead circular FIFO between the fetch (IF) and decode (ID) stages.
// Each entry holds {pc, instruction}. A flush from the execute path discards
// every queued entry; it takes precedence over a push or pop in the same
// cycle. The head entry goes out combinationally from storage, and the
// valid/full flags come only from registered state. There is no path from
// input to output within the same cycle.
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     inValid,
  input  logic [WIDTH-1:0]         pcIn,
  input  logic [WIDTH-1:0]         instructionIn,
  input  logic                     outReady,
  output logic                     outValid,
  output logic [WIDTH-1:0]         pcOut,
  output logic [WIDTH-1:0]         instructionOut,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is not cleared by reset or flush. Only the pointers and the
  // occupancy counter decide which entries are live.
  logic [2*WIDTH-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [2*WIDTH-1:0] head_s;

  // Occupancy flags derived purely from the registered counter
  always_comb begin
    empty_s = (count_r == CNT_W'(0));
    full_s  = (count_r == CNT_W'(DEPTH));
  end

  // Transfer qualification: a flush blocks both directions, a full queue
  // ignores the fetch side and an empty queue ignores the decode side
  always_comb begin
    push_s = inValid  & ~full_s  & ~flush;
    pop_s  = outReady & ~empty_s & ~flush;
  end

  // Next occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and counter state. DEPTH is a power of two, so the natural
  // PTR_W-bit wrap is the modulo-DEPTH advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage write. Writes are gated by rst so nothing lands while the
  // queue is held in reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {pcIn, instructionIn};
    end
  end

  // Head of queue, read at the registered read pointer
  always_comb begin
    head_s = mem_r[rd_ptr_r];
  end

  // Show-ahead outputs, forced to zero while the queue is empty
  always_comb begin
    outValid = ~empty_s;
    full     = full_s;
    count    = count_r;
    if (empty_s) begin
      pcOut          = '0;
      instructionOut = '0;
    end else begin
      pcOut          = head_s[2*WIDTH-1:WIDTH];
      instructionOut = head_s[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
// Directed scenarios plus a randomized run for if_id_queue. Expected values
// come from a plain SystemVerilog queue that models the FIFO rules.
// ---------------------------------------------------------------------------
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             inValid;
  logic [WIDTH-1:0] pcIn;
  logic [WIDTH-1:0] instructionIn;
  logic             outReady;
  logic             outValid;
  logic [WIDTH-1:0] pcOut;
  logic [WIDTH-1:0] instructionOut;
  logic             full;
  logic [2:0]       count;

  int passed;
  int total;

  // Reference model: front of the queue is the head entry, {pc, instr}
  logic [2*WIDTH-1:0] mq [$];

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(inValid),
    .pcIn(pcIn), .instructionIn(instructionIn), .outReady(outReady),
    .outValid(outValid), .pcOut(pcOut), .instructionOut(instructionOut),
    .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, update the model, settle 1 time unit
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] pc,
                       input logic [WIDTH-1:0] ins, input logic rdy,
                       input logic fl);
    bit pu;
    bit po;
    inValid = iv; pcIn = pc; instructionIn = ins; outReady = rdy; flush = fl;
    pu = iv && (mq.size() < DEPTH);
    po = rdy && (mq.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({pc, ins});
    end
    #1;
    inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] exp_pc();
    return (mq.size() > 0) ? mq[0][2*WIDTH-1:WIDTH] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_ins();
    return (mq.size() > 0) ? mq[0][WIDTH-1:0] : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    pcIn = '0; instructionIn = '0;
    #2;
    total++;
    if ({outValid, full, count, pcOut, instructionOut} !== '0)
      $display("FAIL reset_state: got v=%b f=%b c=%0d pc=%h ins=%h, want all 0",
               outValid, full, count, pcOut, instructionOut);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    // first push after reset is accepted on the first edge
    cycle(1'b1, 32'h0000_0100, 32'h1111_0000, 1'b0, 1'b0);
    total++;
    if (count !== 3'd1 || pcOut !== 32'h0000_0100 || outValid !== 1'b1)
      $display("FAIL first_push: got c=%0d pc=%h v=%b, want 1/00000100/1",
               count, pcOut, outValid);
    else passed++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, WIDTH'(4 * i), $urandom, 1'b0, 1'b0);
      total++;
      if (pcOut !== 32'd4 || count !== 3'(i))
        $display("FAIL fill_step%0d: got pc=%h c=%0d, want pc=4 c=%0d",
                 i, pcOut, count, i);
      else passed++;
    end
    total++;
    if (full !== 1'b1)
      $display("FAIL fill_full: got %b, want 1", full);
    else passed++;
    cycle(1'b1, 32'd20, 32'hDEAD_BEEF, 1'b0, 1'b0);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || pcOut !== 32'd4)
      $display("FAIL fill_overflow: got c=%0d f=%b pc=%h, want 4/1/4",
               count, full, pcOut);
    else passed++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (pcOut !== WIDTH'(4 * i) || instructionOut !== exp_ins())
        $display("FAIL drain_head%0d: got pc=%h ins=%h, want pc=%h ins=%h",
                 i, pcOut, instructionOut, 4 * i, exp_ins());
      else passed++;
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    total++;
    if (outValid !== 1'b0 || pcOut !== '0 || count !== 3'd0)
      $display("FAIL drain_empty: got v=%b pc=%h c=%0d, want 0/0/0",
               outValid, pcOut, count);
    else passed++;
    // popping an empty queue does nothing
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    total++;
    if (count !== 3'd0 || outValid !== 1'b0)
      $display("FAIL empty_pop: got c=%0d v=%b, want 0/0", count, outValid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    do_reset();
    cycle(1'b1, 32'h1000, 32'hA000, 1'b0, 1'b0);
    exp = 32'h1000;
    for (int i = 1; i <= 10; i++) begin
      total++;
      if (pcOut !== exp || count !== 3'd1)
        $display("FAIL stream%0d: got pc=%h c=%0d, want pc=%h c=1",
                 i, pcOut, count, exp);
      else passed++;
      cycle(1'b1, WIDTH'(32'h1000 + 4 * i), WIDTH'(32'hA000 + i), 1'b1, 1'b0);
      exp = WIDTH'(32'h1000 + 4 * i);
    end
    total++;
    if (pcOut !== 32'h1028 || instructionOut !== 32'hA00A || count !== 3'd1)
      $display("FAIL stream_end: got pc=%h ins=%h c=%0d, want 1028/a00a/1",
               pcOut, instructionOut, count);
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 32'h4444, 1'b1, 1'b1);
    total++;
    if (count !== 3'd0 || outValid !== 1'b0 || pcOut !== '0)
      $display("FAIL flush_clear: got c=%0d v=%b pc=%h, want 0/0/0",
               count, outValid, pcOut);
    else passed++;
    cycle(1'b1, 32'h80, 32'h8888, 1'b0, 1'b0);
    total++;
    if (pcOut !== 32'h80 || instructionOut !== 32'h8888 || count !== 3'd1)
      $display("FAIL flush_next: got pc=%h ins=%h c=%0d, want 80/8888/1",
               pcOut, instructionOut, count);
    else passed++;
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(32'h200 + 4 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h999, 32'h9999, 1'b1, 1'b0);
    total++;
    if (count !== 3'd3 || full !== 1'b0 || pcOut !== 32'h204)
      $display("FAIL full_pop: got c=%0d f=%b pc=%h, want 3/0/204",
               count, full, pcOut);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pcOut !== WIDTH'(32'h204 + 4 * i))
        $display("FAIL full_pop_drain%0d: got pc=%h, want %h",
                 i, pcOut, 32'h204 + 4 * i);
      else passed++;
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    total++;
    if (outValid !== 1'b0)
      $display("FAIL full_pop_dropped: got v=%b, want 0", outValid);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 32'h300, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, $urandom, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (outValid !== 1'b0 || count !== 3'd0 || pcOut !== '0 || instructionOut !== '0)
      $display("FAIL async_reset: got v=%b c=%0d pc=%h ins=%h, want all 0",
               outValid, count, pcOut, instructionOut);
    else passed++;
    // push and pop requested across an edge while rst is high: ignored
    inValid = 1'b1; outReady = 1'b1; pcIn = 32'h308;
    @(posedge clk); #1;
    total++;
    if (count !== 3'd0 || outValid !== 1'b0)
      $display("FAIL reset_hold: got c=%0d v=%b, want 0/0", count, outValid);
    else passed++;
    rst = 1'b0; inValid = 1'b0; outReady = 1'b0;
    mq.delete();
  endtask

  task automatic test_random();
    logic iv, rdy, fl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      iv  = 1'($urandom_range(0, 99) < 60);
      rdy = 1'($urandom_range(0, 99) < 50);
      fl  = 1'($urandom_range(0, 99) < 4);
      cycle(iv, $urandom, $urandom, rdy, fl);
      total++;
      if (outValid !== (mq.size() > 0) || count !== 3'(mq.size()) ||
          full !== (mq.size() == DEPTH) || pcOut !== exp_pc() ||
          instructionOut !== exp_ins())
        $display("FAIL random%0d: got v=%b c=%0d f=%b pc=%h ins=%h, want v=%b c=%0d f=%b pc=%h ins=%h",
                 i, outValid, count, full, pcOut, instructionOut,
                 mq.size() > 0, mq.size(), mq.size() == DEPTH, exp_pc(), exp_ins());
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_full_pop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
